// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch requester (read-only) and the data memory requester (read/write).
// Each access runs IDLE -> BUSY -> RESP. The winner's done pulse appears in
// RESP, and the stall outputs let the pipeline hold while an access is pending.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,   // 1..15
    parameter int TIMEOUT    = 16   // 2..255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_done_o,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_stall_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic          dm_done_o,
    output logic [DW-1:0] dm_rdata_o,
    output logic          dm_stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          err_o,
    input  logic          err_clr_i
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          owner_dm_q, owner_dm_d;
    logic [3:0]    streak_q, streak_d;
    logic [7:0]    tmo_q, tmo_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_done_q, if_done_d;
    logic          dm_done_q, dm_done_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          err_q, err_d;
    logic          if_wins;

    // IF wins when it is alone, or when DM has held the port STARVE_MAX times in a row
    assign if_wins = if_req_i & (~dm_req_i | (streak_q == STREAK_MAX));

    // Next-state and registered-output logic for the access sequencer
    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = err_q;
        // a clear loses to a timeout in the same cycle, so the set below overrides it
        if (err_clr_i) err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                tmo_d = 8'd0;
                if (if_req_i || dm_req_i) begin
                    state_d   = BUSY;
                    mem_req_d = 1'b1;
                    if (if_wins) begin
                        owner_dm_d  = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        streak_d    = 4'd0;
                    end else begin
                        owner_dm_d  = 1'b1;
                        mem_we_d    = dm_we_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                        // only DM grants that make IF wait count toward starvation
                        if (!if_req_i)
                            streak_d = 4'd0;
                        else if (streak_q != STREAK_MAX)
                            streak_d = streak_q + 4'd1;
                    end
                end else if (!if_req_i) begin
                    streak_d = 4'd0;
                end
            end
            BUSY: begin
                tmo_d = tmo_q + 8'd1;
                if (mem_ack_i) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if_done_d = ~owner_dm_q;
                    dm_done_d = owner_dm_q;
                    // writes leave the owner's read data untouched
                    if (!mem_we_q) begin
                        if (owner_dm_q) dm_rdata_d = mem_rdata_i;
                        else            if_rdata_d = mem_rdata_i;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if_done_d = ~owner_dm_q;
                    dm_done_d = owner_dm_q;
                    err_d     = 1'b1;
                    if (owner_dm_q) dm_rdata_d = '0;
                    else            if_rdata_d = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
                tmo_d   = 8'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any access without a done pulse
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            owner_dm_q  <= 1'b0;
            streak_q    <= 4'd0;
            tmo_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_done_o   = if_done_q;
    assign dm_done_o   = dm_done_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign err_o       = err_q;
    assign if_stall_o  = if_req_i & ~if_done_q;
    assign dm_stall_o  = dm_req_i & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: the bench acts as both requesters and the memory.
// A transaction-level model predicts access windows, done cycles, read data
// and the error flag from grant/ack/timeout cycle arithmetic.
module tb_mem_port_arbiter;
    localparam int SM = 4;
    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_done_o;
    logic [31:0] if_rdata_o;
    logic        if_stall_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic        dm_done_o;
    logic [31:0] dm_rdata_o;
    logic        dm_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        err_o;
    logic        err_clr_i = 1'b0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o),
        .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_done_o(dm_done_o), .dm_rdata_o(dm_rdata_o),
        .dm_stall_o(dm_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .err_o(err_o), .err_clr_i(err_clr_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model state: cycle stamps of the current access and predicted outputs
    int          cyc, free_c, acc_s, acc_e, done_c, ack_c, streak;
    bit          o_dm, o_we, t_out, x_err;
    logic [31:0] o_addr, o_wd, x_ifr, x_dmr;
    logic [31:0] tmem [16];
    bit          dlog [$];
    // requester agents and stimulus knobs
    bit          ia_req, da_req, da_we, clr_next;
    logic [31:0] ia_addr, da_addr, da_wd;
    int          rate_if, rate_dm, dly_mode, noise_pct, clr_pct;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic rst_assert();
        rst_i = 1'b0;
        if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
        mem_ack_i = 1'b0; err_clr_i = 1'b0;
        ia_req = 1'b0; da_req = 1'b0; clr_next = 1'b0;
    endtask

    task automatic rst_release();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        cyc = 0; free_c = 0; acc_s = -100; acc_e = -100; done_c = -100; ack_c = -100;
        streak = 0; t_out = 1'b0; x_err = 1'b0; o_dm = 1'b0; o_we = 1'b0;
        o_addr = '0; o_wd = '0; x_ifr = '0; x_dmr = '0;
    endtask

    // one clock: apply the model's view of the edge, drive inputs, compare outputs
    task automatic step();
        int p, d;
        bit iw, mr, noise;
        @(posedge clk_i); #1;
        cyc++;
        p = cyc - 1;
        if (p == acc_e) begin
            if (t_out) begin
                if (o_dm) x_dmr = '0; else x_ifr = '0;
            end else if (o_we) tmem[o_addr[5:2]] = o_wd;
            else if (o_dm) x_dmr = tmem[o_addr[5:2]];
            else x_ifr = tmem[o_addr[5:2]];
        end
        if (p == acc_e && t_out) x_err = 1'b1;
        else if (err_clr_i) x_err = 1'b0;
        if (p >= free_c && (if_req_i || dm_req_i)) begin
            iw = if_req_i && (!dm_req_i || streak == SM);
            if (iw) begin
                o_dm = 1'b0; o_we = 1'b0; o_addr = if_addr_i; o_wd = '0; streak = 0;
            end else begin
                o_dm = 1'b1; o_we = dm_we_i; o_addr = dm_addr_i; o_wd = dm_wdata_i;
                streak = if_req_i ? ((streak < SM) ? streak + 1 : SM) : 0;
            end
            if (dly_mode >= 0) d = dly_mode;
            else d = ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, 3));
            acc_s = p + 1;
            if (d < TO) begin ack_c = p + 1 + d; acc_e = ack_c; t_out = 1'b0; end
            else begin ack_c = -100; acc_e = p + TO; t_out = 1'b1; end
            done_c = acc_e + 1;
            free_c = acc_e + 2;
        end else if (p >= free_c && !if_req_i) begin
            streak = 0;
        end
        // agents: a finished requester drops, idle ones may issue a new request
        if (cyc == done_c) begin
            if (o_dm) da_req = 1'b0; else ia_req = 1'b0;
        end
        if (!ia_req && $urandom_range(0, 99) < rate_if) begin
            ia_req = 1'b1; ia_addr = 32'($urandom_range(0, 15)) << 2;
        end
        if (!da_req && $urandom_range(0, 99) < rate_dm) begin
            da_req = 1'b1; da_we = 1'($urandom_range(0, 1));
            da_addr = 32'($urandom_range(0, 15)) << 2; da_wd = $urandom;
        end
        mr = (cyc >= acc_s && cyc <= acc_e);
        noise = !mr && ($urandom_range(0, 99) < noise_pct);
        if_req_i = ia_req; if_addr_i = ia_addr;
        dm_req_i = da_req; dm_we_i = da_we; dm_addr_i = da_addr; dm_wdata_i = da_wd;
        mem_ack_i = (cyc == ack_c) || noise;
        mem_rdata_i = (cyc == ack_c) ? tmem[o_addr[5:2]] : $urandom;
        err_clr_i = clr_next || ($urandom_range(0, 99) < clr_pct);
        #1;
        chk("mem_req", 32'(mem_req_o), 32'(mr));
        if (mr) begin
            chk("mem_we", 32'(mem_we_o), 32'(o_we));
            chk("mem_addr", mem_addr_o, o_addr);
            chk("mem_wdata", mem_wdata_o, o_wd);
        end
        chk("if_done", 32'(if_done_o), 32'(cyc == done_c && !o_dm));
        chk("dm_done", 32'(dm_done_o), 32'(cyc == done_c && o_dm));
        chk("if_rdata", if_rdata_o, x_ifr);
        chk("dm_rdata", dm_rdata_o, x_dmr);
        chk("err", 32'(err_o), 32'(x_err));
        chk("if_stall", 32'(if_stall_o), 32'(if_req_i && !(cyc == done_c && !o_dm)));
        chk("dm_stall", 32'(dm_stall_o), 32'(dm_req_i && !(cyc == done_c && o_dm)));
        if (if_done_o) dlog.push_back(1'b0);
        if (dm_done_o) dlog.push_back(1'b1);
    endtask

    typedef struct {
        bit dm; bit we; bit load;
        logic [31:0] addr; logic [31:0] wd; logic [31:0] pre;
        int dly; int x_done; int x_req; logic [31:0] x_rd; bit x_err;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt [8];
        int start, got_done, nreq, nstall;
        logic [31:0] got_rd;
        logic got_err;
        bit pat [10];

        rate_if = 0; rate_dm = 0; dly_mode = 0; noise_pct = 0; clr_pct = 0;
        ia_addr = '0; da_addr = '0; da_wd = '0; da_we = 1'b0;
        for (int i = 0; i < 16; i++) tmem[i] = 32'h1000_0000 + 32'(i);

        // reset state
        rst_assert();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_if_done", 32'(if_done_o), 32'd0);
        chk("rst_dm_done", 32'(dm_done_o), 32'd0);
        chk("rst_if_rdata", if_rdata_o, 32'd0);
        chk("rst_dm_rdata", dm_rdata_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst_release();

        // single-transaction vectors; done/req cycles relative to the request cycle
        //          dm we ld addr        wd            pre           dly x_done x_req x_rd         x_err
        vt[0] = '{0, 0, 1, 32'h04, 32'h0,        32'h8C010004, 0,  2,  1,  32'h8C010004, 0};
        vt[1] = '{1, 0, 1, 32'h08, 32'h0,        32'h00000007, 5,  7,  6,  32'h00000007, 0};
        vt[2] = '{1, 1, 0, 32'h0C, 32'h12345678, 32'h0,        2,  4,  3,  32'h00000007, 0};
        vt[3] = '{0, 0, 0, 32'h0C, 32'h0,        32'h0,        1,  3,  2,  32'h12345678, 0};
        vt[4] = '{0, 0, 1, 32'h30, 32'h0,        32'h77777777, TO, 17, 16, 32'h00000000, 1};
        vt[5] = '{1, 0, 1, 32'h14, 32'h0,        32'hCAFEF00D, 15, 17, 16, 32'hCAFEF00D, 0};
        vt[6] = '{1, 1, 0, 32'h18, 32'h55555555, 32'h0,        TO, 17, 16, 32'h00000000, 1};
        vt[7] = '{1, 0, 1, 32'h1C, 32'h0,        32'h5A5A0001, 0,  2,  1,  32'h5A5A0001, 0};
        for (int i = 0; i < 8; i++) begin
            if (vt[i].load) tmem[vt[i].addr[5:2]] = vt[i].pre;
            dly_mode = vt[i].dly;
            if (vt[i].dm) begin
                da_req = 1'b1; da_we = vt[i].we; da_addr = vt[i].addr; da_wd = vt[i].wd;
            end else begin
                ia_req = 1'b1; ia_addr = vt[i].addr;
            end
            start = cyc + 1; got_done = -1; nreq = 0; nstall = 0;
            got_rd = '0; got_err = 1'b0;
            for (int k = 0; k < 30; k++) begin
                step();
                if (mem_req_o) nreq++;
                if (vt[i].dm ? dm_stall_o : if_stall_o) nstall++;
                if ((vt[i].dm ? dm_done_o : if_done_o) && got_done < 0) begin
                    got_done = cyc - start;
                    got_rd = vt[i].dm ? dm_rdata_o : if_rdata_o;
                    got_err = err_o;
                end
            end
            chk($sformatf("vec%0d_done_cycle", i), 32'(got_done), 32'(vt[i].x_done));
            chk($sformatf("vec%0d_rdata", i), got_rd, vt[i].x_rd);
            chk($sformatf("vec%0d_req_cycles", i), 32'(nreq), 32'(vt[i].x_req));
            chk($sformatf("vec%0d_stall_cycles", i), 32'(nstall), 32'(vt[i].x_done));
            chk($sformatf("vec%0d_err", i), 32'(got_err), 32'(vt[i].x_err));
            clr_next = 1'b1; step(); clr_next = 1'b0; step();
        end

        // simultaneous IF read and DM write: DM first, IF next, DM read data untouched
        dlog.delete();
        tmem[4] = 32'h11112222; dly_mode = 0;
        ia_req = 1'b1; ia_addr = 32'h10;
        da_req = 1'b1; da_we = 1'b1; da_addr = 32'h20; da_wd = 32'hDEADBEEF;
        step(); step();
        chk("simul_first_we", 32'(mem_we_o), 32'd1);
        chk("simul_first_addr", mem_addr_o, 32'h20);
        chk("simul_first_wdata", mem_wdata_o, 32'hDEADBEEF);
        repeat (10) step();
        chk("simul_grants", 32'(dlog.size()), 32'd2);
        if (dlog.size() == 2) begin
            chk("simul_order0_dm", 32'(dlog[0]), 32'd1);
            chk("simul_order1_if", 32'(dlog[1]), 32'd0);
        end
        chk("simul_dm_rdata_kept", dm_rdata_o, 32'h5A5A0001);
        chk("simul_if_rdata", if_rdata_o, 32'h11112222);

        // starvation bound: DM and IF both request continuously
        dlog.delete();
        rate_if = 100; rate_dm = 100;
        repeat (60) step();
        rate_if = 0; rate_dm = 0;
        repeat (10) step();
        for (int k = 0; k < 10; k++) pat[k] = (k % 5 != 4);
        chk("starve_count", 32'(dlog.size() >= 10), 32'd1);
        for (int k = 0; k < 10 && k < dlog.size(); k++)
            chk($sformatf("starve_grant%0d", k), 32'(dlog[k]), 32'(pat[k]));

        // timeout sets err; a clear colliding with a second timeout loses
        dly_mode = TO;
        ia_req = 1'b1; ia_addr = 32'h24;
        step(); step();
        while (cyc < acc_e) step();
        step();
        chk("tmo1_if_done", 32'(if_done_o), 32'd1);
        chk("tmo1_err", 32'(err_o), 32'd1);
        ia_req = 1'b1; ia_addr = 32'h28;
        step(); step();
        while (cyc + 1 < acc_e) step();
        clr_next = 1'b1; step(); clr_next = 1'b0;
        step();
        chk("tmo2_set_wins", 32'(err_o), 32'd1);
        chk("tmo2_if_rdata", if_rdata_o, 32'd0);
        clr_next = 1'b1; step(); clr_next = 1'b0; step();
        chk("err_cleared", 32'(err_o), 32'd0);

        // reset while BUSY drops the request at once and issues no done
        ia_req = 1'b1; ia_addr = 32'h2C;
        repeat (4) step();
        chk("midrst_busy_before", 32'(mem_req_o), 32'd1);
        rst_assert();
        #1;
        chk("midrst_mem_req", 32'(mem_req_o), 32'd0);
        chk("midrst_if_done", 32'(if_done_o), 32'd0);
        @(posedge clk_i); #1;
        chk("midrst_mem_req_hold", 32'(mem_req_o), 32'd0);
        chk("midrst_no_done", 32'(if_done_o), 32'd0);
        rst_release();
        tmem[10] = 32'h0BADF00D; dly_mode = 1;
        ia_req = 1'b1; ia_addr = 32'h28;
        repeat (6) step();
        chk("postrst_if_rdata", if_rdata_o, 32'h0BADF00D);

        // randomized traffic with random ack delays, stray acks and clears
        rate_if = 30; rate_dm = 30; dly_mode = -1; noise_pct = 20; clr_pct = 3;
        repeat (3000) step();
        rate_if = 0; rate_dm = 0;
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (IF, read-only) and the data-memory requester (DM, read/write) of the 5-stage pipeline.
- Sequences each access with a request/acknowledge handshake to the memory.
- Returns read data and a one-cycle done pulse to the granted requester.
- Exposes stall signals so the pipeline registers (PC, IFID, EXMEM/MEMWB) can hold while an access is pending.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_MAX, 4, maximum number of consecutive DM grants while IF is waiting; range 1..15.
- TIMEOUT, 16, cycles in BUSY without mem_ack_i before the access is aborted; range 2..255.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- if_req_i  in  1  IF read request; held until if_done_o.
- if_addr_i  in  AW  IF address; stable while if_req_i is high.
- if_done_o  out  1  one-cycle pulse; IF transaction complete.
- if_rdata_o  out  DW  IF read data; valid with if_done_o, held afterwards.
- if_stall_o  out  1  if_req_i & ~if_done_o (combinational).
- dm_req_i  in  1  DM request; held until dm_done_o.
- dm_we_i  in  1  1 = write, 0 = read.
- dm_addr_i  in  AW  DM address.
- dm_wdata_i  in  DW  DM write data.
- dm_done_o  out  1  one-cycle pulse; DM transaction complete.
- dm_rdata_o  out  DW  DM read data; valid with dm_done_o.
- dm_stall_o  out  1  dm_req_i & ~dm_done_o (combinational).
- mem_req_o  out  1  memory request; held until ack or timeout.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  AW  memory address.
- mem_wdata_o  out  DW  memory write data.
- mem_ack_i  in  1  memory acknowledge; mem_rdata_i is valid in the same cycle.
- mem_rdata_i  in  DW  memory read data.
- err_o  out  1  sticky timeout flag.
- err_clr_i  in  1  synchronous clear of err_o.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE.
  - All outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if/dm_done_o, if/dm_rdata_o, err_o.
  - Streak and timeout counters cleared.
  - A reset mid-transaction drops mem_req_o immediately; no done pulse is issued.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If either request is high, grant one requester and go to BUSY.
  - Register addr, we and wdata from the granted port. For IF, we=0 and wdata=0.
  - Set owner (IF or DM).
- Grant rule:
  - DM has priority by default.
  - IF wins if only IF requests, or if IF requests and streak==STARVE_MAX.
- Streak counter:
  - Increments on a DM grant while if_req_i=1.
  - Clears on an IF grant, or in IDLE when if_req_i=0.
  - Saturates at STARVE_MAX.
- BUSY:
  - mem_req_o=1 and mem_we_o/addr/wdata are driven from registers.
  - Timeout counter increments each cycle.
  - On mem_ack_i: capture mem_rdata_i into the owner's rdata register (reads only; writes leave dm_rdata_o unchanged), then go to RESP.
  - If the counter reaches TIMEOUT-1 without ack: go to RESP, owner rdata=0, err_o=1.
  - mem_req_o deasserts on the edge leaving BUSY.
- RESP:
  - The owner's done_o=1 for exactly this one cycle.
  - No arbitration is performed. Next state is IDLE.
- Latency: request seen in IDLE at cycle 0; mem_req_o high from cycle 1. Ack at cycle k≥1 gives done at cycle k+1 and IDLE again at cycle k+2.
- Minimum access time is 3 cycles (IDLE→BUSY→RESP).
- Non-granted requester: its request stays pending and its stall stays high; it is arbitrated in the next IDLE.
- err_clr_i clears err_o. If err_clr_i and a timeout occur in the same cycle, set wins.
- mem_ack_i outside BUSY is ignored.
- Requests must not drop before done. Behaviour for a request withdrawn mid-BUSY: the access still completes and the done pulse is still emitted.

Test Plan:
- IF only, ack at 1st mem_req cycle, mem_rdata_i=0x8C010004 -> mem_req_o high in cycle 1 only; if_done_o in cycle 2; if_rdata_o=0x8C010004; if_stall_o high cycles 0–1.
- Simultaneous IF read 0x10 and DM write 0x20/0xDEADBEEF -> DM granted first with mem_we_o=1, addr 0x20; then IF granted; dm_rdata_o unchanged.
- DM requesting continuously, IF requesting, STARVE_MAX=4 -> grant sequence DM,DM,DM,DM,IF,DM…; streak clears after the IF grant.
- No ack, TIMEOUT=16 -> mem_req_o high for exactly 16 cycles; done pulse; rdata=0; err_o=1 sticky until err_clr_i; simultaneous err_clr_i and a second timeout leaves err_o=1.
- rst_i low during BUSY -> mem_req_o=0 and state=IDLE immediately; no done pulse; the next request after reset completes normally.
- DM read with ack delayed 5 cycles, mem_rdata_i=0x00000007 -> dm_done_o at cycle 7; dm_rdata_o=7; dm_stall_o high cycles 0–6.
